// File: rtl/traffic_light_pkg.sv
// Phase encodings shared with the UART message select, default phase durations and lamp decode.
// Latency: none (types and constants only); backpressure: none.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        PED    = 2'b11
    } phase_t;

    localparam int DEF_TICK_DIV    = 12_000_000;
    localparam int DEF_GREEN_S     = 10;
    localparam int DEF_YELLOW_S    = 3;
    localparam int DEF_RED_S       = 8;
    localparam int DEF_PED_S       = 6;
    localparam int DEF_MIN_GREEN_S = 4;

    // Lamp pattern {green, yellow, red, walk}; red stays lit through PED.
    function automatic logic [3:0] phase_lamps(phase_t p);
        logic [3:0] lamps;
        case (p)
            GREEN:   lamps = 4'b1000;
            YELLOW:  lamps = 4'b0100;
            RED:     lamps = 4'b0010;
            PED:     lamps = 4'b0011;
            default: lamps = 4'b0010;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Lamp, phase-code and pedestrian-button bundle of the traffic-light node.
// Latency: none (wiring only); backpressure: none, outputs are level/pulse signals.
interface traffic_light_sequencer_if;
    logic       ped_btn;
    logic       light_g;
    logic       light_y;
    logic       light_r;
    logic       ped_walk;
    logic [1:0] state_code;
    logic       state_change;
    logic [7:0] secs_left;

    modport master (
        input  ped_btn,
        output light_g, light_y, light_r, ped_walk,
        output state_code, state_change, secs_left
    );

    modport slave (
        output ped_btn,
        input  light_g, light_y, light_r, ped_walk,
        input  state_code, state_change, secs_left
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the clock into a one-cycle tick every TICK_DIV cycles, restartable by clear.
// Latency: tick is combinational from the count register; backpressure: none.
module tick_prescaler #(
    parameter int TICK_DIV = 12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] L_LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || r_cnt == L_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign tick = (r_cnt == L_LAST);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Timed GREEN/YELLOW/RED cycle with a pedestrian phase on request; all outputs registered.
// Latency: exit tick at T shows new phase at T+1, button to pending 3 cycles; backpressure: none.
module traffic_light_sequencer
    import traffic_light_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int GREEN_S     = DEF_GREEN_S,
    parameter int YELLOW_S    = DEF_YELLOW_S,
    parameter int RED_S       = DEF_RED_S,
    parameter int PED_S       = DEF_PED_S,
    parameter int MIN_GREEN_S = DEF_MIN_GREEN_S
) (
    input  logic                      clk,
    input  logic                      rst_n,
    traffic_light_sequencer_if.master bus
);

    localparam logic [7:0] L_GREEN     = 8'(GREEN_S);
    localparam logic [7:0] L_YELLOW    = 8'(YELLOW_S);
    localparam logic [7:0] L_RED       = 8'(RED_S);
    localparam logic [7:0] L_PED       = 8'(PED_S);
    localparam logic [7:0] L_MIN_GREEN = 8'(MIN_GREEN_S);

    phase_t     r_phase;
    logic [7:0] r_e;
    logic [7:0] r_secs;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_btn_q;
    logic       r_pending;
    logic       r_light_g;
    logic       r_light_y;
    logic       r_light_r;
    logic       r_ped_walk;
    logic       r_change;

    logic       w_tick;
    logic       w_btn_edge;
    logic       w_req;
    logic       w_exit;
    logic [7:0] w_dur;
    logic [7:0] w_e_next;
    phase_t     w_next;

    function automatic logic [7:0] dur_of(phase_t p);
        logic [7:0] d;
        case (p)
            GREEN:   d = L_GREEN;
            YELLOW:  d = L_YELLOW;
            RED:     d = L_RED;
            PED:     d = L_PED;
            default: d = L_GREEN;
        endcase
        return d;
    endfunction

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_exit),
        .tick  (w_tick)
    );

    // A fresh edge counts as a request on its own cycle, so it wins a coincident RED exit.
    always_comb begin
        w_dur      = dur_of(r_phase);
        w_e_next   = r_e + 8'd1;
        w_btn_edge = r_sync2 & ~r_btn_q;
        w_req      = r_pending | (w_btn_edge & (r_phase != PED));
        w_exit     = w_tick & ((w_e_next == w_dur) |
                               ((r_phase == GREEN) & w_req & (w_e_next >= L_MIN_GREEN)));
        case (r_phase)
            GREEN:   w_next = YELLOW;
            YELLOW:  w_next = RED;
            RED:     w_next = w_req ? PED : GREEN;
            PED:     w_next = GREEN;
            default: w_next = GREEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= GREEN;
            r_e        <= 8'd0;
            r_secs     <= L_GREEN;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_btn_q    <= 1'b0;
            r_pending  <= 1'b0;
            r_light_g  <= 1'b1;
            r_light_y  <= 1'b0;
            r_light_r  <= 1'b0;
            r_ped_walk <= 1'b0;
            r_change   <= 1'b0;
        end else begin
            r_sync1  <= bus.ped_btn;
            r_sync2  <= r_sync1;
            r_btn_q  <= r_sync2;
            r_change <= w_exit;

            if (w_exit) begin
                r_phase <= w_next;
                r_e     <= 8'd0;
                r_secs  <= dur_of(w_next);
                {r_light_g, r_light_y, r_light_r, r_ped_walk} <= phase_lamps(w_next);
            end else if (w_tick) begin
                r_e    <= w_e_next;
                r_secs <= r_secs - 8'd1;
            end

            // Requests raised during the walk itself are dropped.
            if (w_exit && w_next == PED) begin
                r_pending <= 1'b0;
            end else if (w_btn_edge && r_phase != PED) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.state_code   = r_phase;
    assign bus.light_g      = r_light_g;
    assign bus.light_y      = r_light_y;
    assign bus.light_r      = r_light_r;
    assign bus.ped_walk     = r_ped_walk;
    assign bus.state_change = r_change;
    assign bus.secs_left    = r_secs;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Self-checking bench: cycle-count reference model compared every cycle, plus literal timeline checks.
module tb_traffic_light_sequencer;

    localparam int TD = 10;
    localparam int GS = 5;
    localparam int YS = 2;
    localparam int RS = 3;
    localparam int PS = 4;
    localparam int MG = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    traffic_light_sequencer_if tl_if ();

    traffic_light_sequencer #(
        .TICK_DIV    (TD),
        .GREEN_S     (GS),
        .YELLOW_S    (YS),
        .RED_S       (RS),
        .PED_S       (PS),
        .MIN_GREEN_S (MG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tl_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int k;

    // Model: phase 0=G 1=Y 2=R 3=P, cycles spent in phase, request flag, change flag.
    int m_phase;
    int m_c;
    bit m_pend;
    bit m_chg;
    bit bhist[$];

    function automatic int dur(int p);
        case (p)
            0:       return GS;
            1:       return YS;
            2:       return RS;
            default: return PS;
        endcase
    endfunction

    function automatic bit btn_at(int j);
        if (j < 0 || j >= bhist.size()) return 1'b0;
        return bhist[j];
    endfunction

    // A press reaches the request logic two edges after it is sampled, once per rising level.
    function automatic bit press_seen(int j);
        return btn_at(j - 2) && !btn_at(j - 3);
    endfunction

    function automatic logic [14:0] expect_vec();
        logic [1:0] pc;
        logic [3:0] lamps;
        logic [7:0] secs;
        pc    = 2'(m_phase);
        lamps = {m_phase == 0, m_phase == 1, m_phase >= 2, m_phase == 3};
        secs  = 8'(dur(m_phase) - m_c / TD);
        return {pc, lamps, m_chg, secs};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {tl_if.state_code, tl_if.light_g, tl_if.light_y, tl_if.light_r,
                tl_if.ped_walk, tl_if.state_change, tl_if.secs_left};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_c     = 0;
        m_pend  = 1'b0;
        m_chg   = 1'b0;
        bhist.delete();
        k = 0;
    endtask

    task automatic model_edge(input bit b);
        bit ev, tick, req, leave;
        int ticks, nxt;
        bhist.push_back(b);
        ev    = press_seen(k);
        ticks = m_c / TD;
        tick  = (m_c % TD) == TD - 1;
        req   = m_pend || (ev && m_phase != 3);
        leave = tick && ((ticks + 1 == dur(m_phase)) ||
                         (m_phase == 0 && req && ticks + 1 >= MG));
        if (ev && m_phase != 3) m_pend = 1'b1;
        if (leave) begin
            if (m_phase == 2)      nxt = req ? 3 : 0;
            else if (m_phase == 3) nxt = 0;
            else                   nxt = m_phase + 1;
            if (nxt == 3) m_pend = 1'b0;
            m_phase = nxt;
            m_c     = 0;
            m_chg   = 1'b1;
        end else begin
            m_c++;
            m_chg = 1'b0;
        end
    endtask

    // One cycle: compare at the negedge, drive the button for the next edge, advance the model.
    task automatic cycle(input bit b);
        chk("outputs", int'(dut_vec()), int'(expect_vec()));
        tl_if.ped_btn = b;
        model_edge(b);
        k++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tl_if.ped_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int walk_cnt, nz, chg_cnt;
        bit rb;
        rst_n = 1'b0;
        tl_if.ped_btn = 1'b0;
        k = 0;
        @(negedge clk);

        // Free run, no button.
        do_reset();
        for (int i = 0; i < 110; i++) begin
            case (i)
                0: begin
                    chk("rst_code", int'(tl_if.state_code), 0);
                    chk("rst_lamps", int'({tl_if.light_g, tl_if.light_y, tl_if.light_r, tl_if.ped_walk}), 4'b1000);
                    chk("rst_secs", int'(tl_if.secs_left), 5);
                    chk("rst_change", int'(tl_if.state_change), 0);
                end
                10: chk("secs_4", int'(tl_if.secs_left), 4);
                20: chk("secs_3", int'(tl_if.secs_left), 3);
                30: chk("secs_2", int'(tl_if.secs_left), 2);
                40: chk("secs_1", int'(tl_if.secs_left), 1);
                49: chk("green_end", int'(tl_if.state_code), 0);
                50: chk("yellow_start", int'({tl_if.state_code, tl_if.state_change}), 3'b011);
                51: chk("change_one_cycle", int'(tl_if.state_change), 0);
                70: chk("red_start", int'({tl_if.state_code, tl_if.state_change}), 3'b101);
                99: chk("red_end", int'(tl_if.state_code), 2);
                100: chk("green_again", int'({tl_if.state_code, tl_if.state_change}), 3'b001);
                default: ;
            endcase
            cycle(1'b0);
        end

        // Button high for cycles 5-7: early green exit, then PED.
        do_reset();
        for (int i = 0; i < 120; i++) begin
            case (i)
                19: chk("early_green_hold", int'(tl_if.state_code), 0);
                20: chk("early_yellow", int'(tl_if.state_code), 1);
                40: chk("red_after_early", int'(tl_if.state_code), 2);
                69: chk("red_before_ped", int'(tl_if.light_r), 1);
                70: chk("ped_start", int'({tl_if.state_code, tl_if.light_r, tl_if.ped_walk}), 4'b1111);
                110: chk("green_after_ped", int'(tl_if.state_code), 0);
                default: ;
            endcase
            cycle(i >= 5 && i <= 7);
        end

        // Press during yellow: full green, PED after red.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            case (i)
                49: chk("full_green", int'(tl_if.state_code), 0);
                100: chk("ped_after_yellow_press", int'(tl_if.state_code), 3);
                139: chk("ped_40_cycles", int'(tl_if.ped_walk), 1);
                140: chk("green_after_40", int'(tl_if.state_code), 0);
                default: ;
            endcase
            cycle(i >= 55 && i <= 57);
        end

        // Held button: exactly one PED phase.
        do_reset();
        walk_cnt = 0;
        for (int i = 0; i < 330; i++) begin
            if (tl_if.ped_walk) walk_cnt++;
            if (i == 210) chk("held_no_second_ped", int'(tl_if.state_code), 0);
            cycle(i >= 3 && i < 303);
        end
        chk("held_one_ped", walk_cnt, 40);

        // Press during PED is ignored.
        do_reset();
        for (int i = 0; i < 220; i++) begin
            case (i)
                110: chk("green_after_ped2", int'(tl_if.state_code), 0);
                160: chk("yellow_no_pending", int'(tl_if.state_code), 1);
                209: chk("red_end2", int'(tl_if.state_code), 2);
                210: chk("red_to_green", int'(tl_if.state_code), 0);
                default: ;
            endcase
            cycle((i >= 5 && i <= 7) || (i >= 80 && i <= 82));
        end

        // Randomised button activity against the model.
        do_reset();
        rb = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) rb = ~rb;
            cycle(rb);
        end

        // Reset asserted mid-RED.
        do_reset();
        for (int i = 0; i < 85; i++) cycle(1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(dut_vec()), int'({2'b00, 4'b1000, 1'b0, 8'd5}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        nz = 0;
        chg_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (i < 50) begin
                if (tl_if.state_code != 2'b00) nz++;
                if (tl_if.state_change) chg_cnt++;
            end
            if (i == 50) chk("post_reset_yellow", int'(tl_if.state_code), 1);
            cycle(1'b0);
        end
        chk("post_reset_green_50", nz, 0);
        chk("post_reset_no_pulse", chg_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Timed phase controller for the traffic-light node. Cycles the intersection through GREEN, YELLOW and RED, and inserts a PEDESTRIAN walk phase on request. Drives the lamp outputs and the 2-bit phase code that selects the UART status message (00 Green, 01 Yellow, 10 Red, 11 Pedestrian). The UART transmitter sends a message whenever this code changes.

## Interface

Parameters:
- `TICK_DIV`, default 12_000_000: clock cycles per one-second tick (12 MHz board clock).
- `GREEN_S`, default 10: green duration in ticks.
- `YELLOW_S`, default 3: yellow duration in ticks.
- `RED_S`, default 8: red duration in ticks.
- `PED_S`, default 6: pedestrian walk duration in ticks.
- `MIN_GREEN_S`, default 4: minimum green duration before a pedestrian request may cut green short.
- Legal range for all durations is 1..255. `MIN_GREEN_S` must not exceed `GREEN_S`.

Ports:
- `clk` in 1: single system clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `ped_btn` in 1: pedestrian push button, asynchronous, active-high.
- `light_g` out 1: green lamp.
- `light_y` out 1: yellow lamp.
- `light_r` out 1: red lamp. Also high during PED.
- `ped_walk` out 1: walk lamp. High only in PED.
- `state_code` out 2: phase code feeding the UART message select.
- `state_change` out 1: one-cycle pulse on the first cycle of each new phase.
- `secs_left` out 8: ticks remaining in the current phase.

## Operation

- **Phase states:** GREEN, YELLOW, RED, PED. All outputs are registered.
- **Transitions:**
  - GREEN -> YELLOW.
  - YELLOW -> RED.
  - RED -> PED if a request is pending, otherwise RED -> GREEN.
  - PED -> GREEN.
- **Prescaler:**
  - Produces a one-cycle `tick` when its count reaches `TICK_DIV-1`.
  - Is cleared on every phase entry. Each phase therefore lasts exactly N*`TICK_DIV` cycles.
- **Elapsed counter `e` (8 bit):**
  - Cleared on phase entry.
  - Increments on each `tick`.
  - The phase exits on the tick where `e+1` equals the phase duration.
- **Early green exit:** in GREEN with a request pending, the phase exits on the first tick where `e+1 >= MIN_GREEN_S`.
- **`secs_left`:**
  - Equals duration minus `e`.
  - Loads the full duration on entry.
  - Never wraps below 1 while in a phase.
- **Button path:**
  - 2-flop synchronizer, then rising-edge detect.
  - A detected edge sets `ped_pending`.
  - A held button produces exactly one request.
  - Edges detected while in PED are ignored.
  - `ped_pending` clears on the cycle PED is entered.
- **Simultaneous events:** if an edge is detected on the same cycle as the RED exit tick, the request is taken (set dominates the RED decision) and PED is entered.

## Timing

- Reset state (asynchronous, immediate on `rst_n` low):
  - Phase GREEN, `state_code`=00.
  - `light_g`=1, `light_y`=0, `light_r`=0, `ped_walk`=0.
  - `state_change`=0, `secs_left`=`GREEN_S`.
  - Prescaler, `e`, synchronizer and `ped_pending` all cleared.
- Reset asserted mid-phase aborts the phase. No `state_change` pulse is produced on reset entry or release.
- Exit tick at cycle T: `state_code`, lamps and `secs_left` show the new phase at T+1, and `state_change`=1 during T+1 only.
- Button-to-pending latency is 3 cycles (2 sync flops plus edge register).
- `light_r` stays continuously high across the RED->PED boundary, with no glitch.

## Structure

- Package `traffic_light_pkg` holds:
  - The phase enum with encodings GREEN=2'b00, YELLOW=2'b01, RED=2'b10, PED=2'b11. These encodings are shared with the UART message select.
  - The default duration constants.
- Sub-module `tick_prescaler`:
  - Parameter `TICK_DIV`; ports `clk`, `rst_n`, `clear`, `tick`.
  - Counter width is `$clog2(TICK_DIV)`.
- The FSM, counter, button path and output registers live in `traffic_light_sequencer`.

## Test plan

All scenarios use `TICK_DIV`=10, `GREEN_S`=5, `YELLOW_S`=2, `RED_S`=3, `PED_S`=4, `MIN_GREEN_S`=2. Cycle 0 is the first edge after reset release.

- **Free run, no button:** `state_code` is 00 for cycles 0-49, 01 for 50-69, 10 for 70-99, and 00 again from 100. `state_change` pulses at 50, 70 and 100. `secs_left` counts 5,4,3,2,1 in green.
- **Button high for cycles 5-7:** green exits at the tick on cycle 19, so `state_code`=01 at cycle 20. Then 10 at 40, 11 at 70 with `ped_walk`=1 and `light_r`=1, and 00 at 110.
- **Button pressed during YELLOW:** green runs its full 5 ticks. After RED, the PED phase is entered for 40 cycles.
- **Button held high for 300 cycles starting in GREEN:** exactly one PED phase is served. The following cycle runs GREEN->YELLOW->RED->GREEN with no PED.
- **Button press during PED:** ignored. The next RED exits to GREEN with `state_code`=00.
- **`rst_n` pulled low at cycle 85 (mid-RED):** outputs take the reset values within the same cycle. After release, `state_code` holds 00 for a full 50 cycles, with no `state_change` pulse at release.
